// File: rtl/breakout_motion_pkg.sv
// rtl/breakout_motion_pkg.sv - shared types, constants and helpers for ball motion control
package breakout_motion_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_PLAY
    } ball_state_t;

    localparam logic [2:0] CODE_STILL      = 3'd4;
    localparam int         DEF_SPEED2_HITS = 4;
    localparam int         DEF_SPEED3_HITS = 12;

    // Outer paddle segments deflect harder than the inner ones.
    function automatic logic signed [2:0] zone_to_vx(input logic [1:0] zone);
        case (zone)
            2'd0:    return -3'sd2;
            2'd1:    return -3'sd1;
            2'd2:    return  3'sd1;
            default: return  3'sd2;
        endcase
    endfunction

    function automatic logic [2:0] encode_code(input logic signed [2:0] v);
        return CODE_STILL + $unsigned(v);
    endfunction

endpackage

// File: rtl/hit_event_latch.sv
// rtl/hit_event_latch.sv - per-frame sticky collision flags with paddle zone capture
module hit_event_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic       paddle_hit,
    input  logic [1:0] paddle_zone,
    input  logic       side_hit,
    input  logic       top_hit,
    input  logic       brick_hit,
    output logic       paddle_flag,
    output logic [1:0] zone,
    output logic       side_flag,
    output logic       top_flag,
    output logic       brick_flag
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddle_flag <= 1'b0;
            zone        <= 2'd0;
            side_flag   <= 1'b0;
            top_flag    <= 1'b0;
            brick_flag  <= 1'b0;
        end else if (clear || !enable) begin
            paddle_flag <= 1'b0;
            zone        <= 2'd0;
            side_flag   <= 1'b0;
            top_flag    <= 1'b0;
            brick_flag  <= 1'b0;
        end else if (frame_tick) begin
            // Events coincident with the tick belong to the next frame.
            paddle_flag <= paddle_hit;
            zone        <= paddle_hit ? paddle_zone : zone;
            side_flag   <= side_hit;
            top_flag    <= top_hit;
            brick_flag  <= brick_hit;
        end else begin
            paddle_flag <= paddle_flag | paddle_hit;
            if (paddle_hit && !paddle_flag)
                zone <= paddle_zone;
            side_flag   <= side_flag  | side_hit;
            top_flag    <= top_flag   | top_hit;
            brick_flag  <= brick_flag | brick_hit;
        end
    end

endmodule

// File: rtl/ball_direction_control.sv
// rtl/ball_direction_control.sv - serve/miss FSM and per-frame ball velocity code generation
module ball_direction_control
    import breakout_motion_pkg::*;
#(
    parameter int SPEED2_HITS = DEF_SPEED2_HITS,
    parameter int SPEED3_HITS = DEF_SPEED3_HITS
) (
    input  logic       CLK_DRV,
    input  logic       RESET,
    input  logic       FRAME_TICK,
    input  logic       SERVE,
    input  logic       SERVE_DIR,
    input  logic       BALL_MISS,
    input  logic       PADDLE_HIT,
    input  logic [1:0] PADDLE_ZONE,
    input  logic       SIDE_HIT,
    input  logic       TOP_HIT,
    input  logic       BRICK_HIT,
    output logic       CX0,
    output logic       CX1,
    output logic       X2,
    output logic       Y0,
    output logic       Y1,
    output logic       Y2,
    output logic       BALL_ACTIVE,
    output logic [1:0] SPEED
);

    localparam logic [3:0] HITS2 = 4'(SPEED2_HITS);
    localparam logic [3:0] HITS3 = 4'(SPEED3_HITS);

    ball_state_t       state;
    logic signed [2:0] vx;
    logic signed [2:0] vy;
    logic signed [2:0] vx_next;
    logic signed [2:0] vy_next;
    logic        [3:0] hit_count;
    logic              top_sticky;
    logic        [2:0] h_code;
    logic        [2:0] v_code;
    logic        [1:0] mag;
    logic signed [2:0] mag_s;
    logic signed [2:0] signed_mag;
    logic              vy_down;

    logic       paddle_flag;
    logic [1:0] zone;
    logic       side_flag;
    logic       top_flag;
    logic       brick_flag;

    hit_event_latch u_hit_event_latch (
        .clk         (CLK_DRV),
        .rst         (RESET),
        .enable      (state == ST_PLAY),
        .clear       (BALL_MISS),
        .frame_tick  (FRAME_TICK),
        .paddle_hit  (PADDLE_HIT),
        .paddle_zone (PADDLE_ZONE),
        .side_hit    (SIDE_HIT),
        .top_hit     (TOP_HIT),
        .brick_hit   (BRICK_HIT),
        .paddle_flag (paddle_flag),
        .zone        (zone),
        .side_flag   (side_flag),
        .top_flag    (top_flag),
        .brick_flag  (brick_flag)
    );

    always_comb begin
        mag = 2'd1;
        if (top_sticky || top_flag || hit_count >= HITS3)
            mag = 2'd3;
        else if (hit_count >= HITS2)
            mag = 2'd2;
    end

    // vy is never zero in play, so its sign bit alone gives the direction.
    assign vy_down    = !vy[2];
    assign mag_s      = signed'({1'b0, mag});
    assign signed_mag = vy_down ? mag_s : -mag_s;

    always_comb begin
        vy_next = signed_mag;
        if (paddle_flag && vy_down)
            vy_next = -mag_s;
        else if (top_flag && !vy_down)
            vy_next = mag_s;
        else if (brick_flag)
            vy_next = -signed_mag;

        vx_next = vx;
        if (paddle_flag)
            vx_next = zone_to_vx(zone);
        else if (side_flag)
            vx_next = -vx;
    end

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            vx          <= 3'sd0;
            vy          <= 3'sd0;
            hit_count   <= 4'd0;
            top_sticky  <= 1'b0;
            h_code      <= CODE_STILL;
            v_code      <= CODE_STILL;
            BALL_ACTIVE <= 1'b0;
            SPEED       <= 2'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (SERVE) begin
                        state       <= ST_PLAY;
                        vx          <= SERVE_DIR ? 3'sd1 : -3'sd1;
                        vy          <= 3'sd1;
                        hit_count   <= 4'd0;
                        top_sticky  <= 1'b0;
                        h_code      <= encode_code(SERVE_DIR ? 3'sd1 : -3'sd1);
                        v_code      <= encode_code(3'sd1);
                        BALL_ACTIVE <= 1'b1;
                        SPEED       <= 2'd1;
                    end
                end
                default: begin
                    if (BALL_MISS) begin
                        state       <= ST_IDLE;
                        vx          <= 3'sd0;
                        vy          <= 3'sd0;
                        h_code      <= CODE_STILL;
                        v_code      <= CODE_STILL;
                        BALL_ACTIVE <= 1'b0;
                    end else begin
                        if (BRICK_HIT && hit_count != 4'd15)
                            hit_count <= hit_count + 4'd1;
                        if (FRAME_TICK) begin
                            vx         <= vx_next;
                            vy         <= vy_next;
                            h_code     <= encode_code(vx_next);
                            v_code     <= encode_code(vy_next);
                            top_sticky <= top_sticky | top_flag;
                            SPEED      <= mag;
                        end
                    end
                end
            endcase
        end
    end

    assign {X2, CX1, CX0} = h_code;
    assign {Y2, Y1, Y0}   = v_code;

endmodule
